// File: rtl/neuron_accum.sv
// Neuron accumulate/activate stage: sums N_INPUTS signed products, adds bias, shifts and saturates.
// Optional macro NEURON_RELU_EN clamps negative results to zero instead of signed saturation.
module neuron_accum #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned SHIFT    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_prod,
  input  logic [15:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_act,
  output logic        sat_flag,
  output logic [7:0]  count
);

  localparam int unsigned CntW = $clog2(N_INPUTS + 1);
  // One extra bit so adding the bias can never wrap.
  localparam int unsigned SumW = ACC_W + 1;

  localparam logic signed [SumW-1:0] MaxAct = SumW'(127);
  localparam logic signed [SumW-1:0] MinAct = -SumW'(128);

  typedef enum logic [0:0] {
    StAcc,
    StFin
  } state_e;

  state_e                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CntW-1:0]         r_count;
  logic                    r_out_valid;
  logic [7:0]              r_out_act;
  logic                    r_sat;

  logic signed [SumW-1:0]  w_sum;
  logic signed [SumW-1:0]  w_shr;
  logic [ACC_W-1:0]        w_prod_ext;
  logic [7:0]              w_act;
  logic                    w_clamp;
  logic                    w_last;
  logic                    w_commit;

  assign w_prod_ext = {{(ACC_W - 16){in_prod[15]}}, in_prod};
  assign w_last     = (r_count == CntW'(N_INPUTS - 1));
  // Commit when the result register is empty or is being drained this cycle.
  assign w_commit   = (r_state == StFin) && (!r_out_valid || out_ready);

  assign w_sum = $signed({r_acc[ACC_W-1], r_acc}) + $signed({{(SumW - 16){bias[15]}}, bias});
  assign w_shr = w_sum >>> SHIFT;

  always_comb begin
    w_act   = w_shr[7:0];
    w_clamp = 1'b0;
`ifdef NEURON_RELU_EN
    if (w_shr[SumW-1]) begin
      w_act = 8'h00;
    end else if (w_shr > MaxAct) begin
      w_act   = 8'h7F;
      w_clamp = 1'b1;
    end
`else
    if (w_shr > MaxAct) begin
      w_act   = 8'h7F;
      w_clamp = 1'b1;
    end else if (w_shr < MinAct) begin
      w_act   = 8'h80;
      w_clamp = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StAcc;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_act   <= 8'h00;
      r_sat       <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        StAcc: begin
          if (in_valid) begin
            r_acc   <= r_acc + w_prod_ext;
            r_count <= r_count + CntW'(1);
            if (w_last) begin
              r_state <= StFin;
            end
          end
        end
        StFin: begin
          // A stalled FIN keeps acc frozen and retries every cycle.
          if (w_commit) begin
            r_out_act   <= w_act;
            r_out_valid <= 1'b1;
            r_sat       <= r_sat | w_clamp;
            r_acc       <= '0;
            r_count     <= '0;
            r_state     <= StAcc;
          end
        end
        default: r_state <= StAcc;
      endcase
    end
  end

  assign in_ready  = (r_state == StAcc);
  assign out_valid = r_out_valid;
  assign out_act   = r_out_act;
  assign sat_flag  = r_sat;
  assign count     = 8'(r_count);

endmodule

// File: doc/neuron_accum.md
NEURON_ACCUM -- requirements
Module: neuron_accum

Interface
REQ-001 Parameters SHALL be: N_INPUTS, default 8, products summed per neuron (2..256); ACC_W, default 24, accumulator width (at least 17+clog2(N_INPUTS)); SHIFT, default 7, arithmetic right-shift applied before saturation.
REQ-002 Ports SHALL be, one per line:
  clk        in   1      single clock, rising edge
  reset      in   1      synchronous, active-high reset
  in_valid   in   1      in_prod holds a valid product this cycle
  in_ready   out  1      stage accepts a product this cycle
  in_prod    in   16     product from the 8x8 multiplier, 16-bit two's complement
  bias       in   16     neuron bias, two's complement, sampled in FIN
  out_valid  out  1      out_act holds a valid activation
  out_ready  in   1      downstream accepts out_act this cycle
  out_act    out  8      activation, 8-bit two's complement
  sat_flag   out  1      sticky: some result saturated since reset
  count      out  8      products accepted in the current neuron

Function
REQ-003 Transfers SHALL occur only on cycles where valid and ready are both high, on the input and output sides independently.
REQ-004 The FSM SHALL have two states: ACC and FIN.
REQ-005 In ACC: in_ready=1; each input transfer adds the sign-extended in_prod to acc and increments count; the transfer taking count to N_INPUTS moves the FSM to FIN.
REQ-006 In FIN: in_ready=0; r = (acc + sext(bias)) >>> SHIFT, with arithmetic shift and floor rounding.
REQ-007 r SHALL saturate to [-128, 127]; when clamping occurs, sat_flag is set and stays set until reset.
REQ-008 FIN SHALL commit when the result register is empty, or is being drained this cycle (out_valid && out_ready). On commit: load out_act, set out_valid, clear acc and count, go to ACC.
REQ-009 If FIN cannot commit, the FSM SHALL stay in FIN with acc frozen and re-evaluate every cycle; bias must be held stable by the source.
REQ-010 Latency: last product accepted at edge t -> out_valid high after edge t+1, provided the result register is free.
REQ-011 Once out_valid is high, out_act SHALL hold stable until the cycle out_ready is high; out_valid then drops unless FIN commits in the same cycle, in which case the new value appears with no bubble.
REQ-012 Steady-state throughput SHALL be N_INPUTS products per N_INPUTS+1 cycles.
REQ-013 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-014 The accumulator SHALL not wrap for any N_INPUTS legal products.

Reset
REQ-015 While reset is high at a clock edge: state=ACC, acc=0, count=0, out_valid=0, out_act=0x00, sat_flag=0; in_ready is high in the cycle after.
REQ-016 Reset mid-accumulation or in FIN SHALL discard the partial sum and any pending result with no output.

Configuration
REQ-017 Macro NEURON_RELU_EN: when defined, results below zero become 0x00 before saturation, and they do not set sat_flag. When undefined, results are signed-saturated to [-128, 127].

Verification (N_INPUTS=8, ACC_W=24, SHIFT=7)
REQ-018 8 x 0x0100, bias 0x0000, out_ready=1 -> out_act=0x10, out_valid high exactly one cycle after the 8th accepted product, sat_flag=0.
REQ-019 8 x 0xFF00, bias 0 -> out_act=0x00 with NEURON_RELU_EN, 0xF0 without; bias 0xFFFF with zero products -> 0x00 / 0xFF.
REQ-020 8 x 0x7FFF, bias 0 -> sum 262136, r=2047 -> out_act=0x7F, sat_flag=1 and stays 1 across later unsaturated results.
REQ-021 out_ready=0, two 8-product vectors -> first result held stable, FSM stalls in FIN with in_ready=0; out_ready=1 for one cycle -> first consumed, second appears next cycle, in_ready returns high.
REQ-022 reset asserted after 4 products -> count=0, out_valid=0; then 8 x 0x0080 -> out_act=0x08, unaffected by the discarded products.
REQ-023 in_valid toggled randomly with 8 x 0x0100 -> only accepted transfers are counted; result 0x10.
